occupancy_updater: RTL and testbench
====================================

# occupancy_updater

Read-modify-write stage downstream of the Bresenham ray tracer. It consumes the per-cell stream produced while a ray is traced: one occupied endpoint update followed by free-cell updates, at up to one per clock. For each update it reads the cell's log-odds value from the occupancy-map RAM, applies a saturating increment or decrement, and writes the result back. It also owns map clearing, and it drives the `busy` signal that the ray tracer samples as `occupancy_busy` before starting a new ray.

## Interface
- `X_BITS`, 5: cell x coordinate width
- `Y_BITS`, 5: cell y coordinate width; RAM address is `{cell_y, cell_x}`, ADDR_BITS = X_BITS+Y_BITS
- `CELL_BITS`, 8: signed two's-complement log-odds width
- `OCC_INC`, 4: amount added for an occupied update (positive, < 2^(CELL_BITS-1))
- `FREE_DEC`, 1: amount subtracted for a free update (positive, < 2^(CELL_BITS-1))

Ports:
- `clock`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; 0 resets all state immediately
- `write_enable`  in  1  update valid this cycle
- `cell_is_free`  in  1  1 = free update (subtract FREE_DEC), 0 = occupied (add OCC_INC)
- `cell_x`  in  X_BITS  update cell x
- `cell_y`  in  Y_BITS  update cell y
- `clear`  in  1  request to zero the whole map; honoured only when `busy`=0
- `busy`  out  1  high while a clear runs or an update write is pending
- `update_dropped`  out  1  sticky; set when an update is discarded
- `mem_raddr`  out  ADDR_BITS  RAM read address; combinational `{cell_y, cell_x}`
- `mem_rdata`  in  CELL_BITS  RAM read data; valid one cycle after address is sampled
- `mem_waddr`  out  ADDR_BITS  RAM write address
- `mem_wdata`  out  CELL_BITS  RAM write data
- `mem_we`  out  1  RAM write strobe

## Operation
- The RAM is simple dual-port with a 1-cycle synchronous read. Read-during-write to the same address returns the old data, which is why the block forwards write data itself (see below).
- Reset values: `busy`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `update_dropped`=0. FSM returns to IDLE, the clear counter goes to 0 and S1 is marked invalid.
- FSM states:
  - IDLE: accepts updates.
  - CLEAR: writes zeros across the map. Updates are not accepted.
- Transitions:
  - IDLE→CLEAR when `clear`=1 and `busy`=0.
  - CLEAR→IDLE after the write at address 2^ADDR_BITS−1.
- Update pipeline, with an update sampled at edge N in IDLE:
  - At edge N, register stage S1 captures valid, address and free flag.
  - Forwarding: if S1 was already valid at edge N with the same address (its write commits at edge N), S1 also captures that write data as a forwarded operand and sets `fwd`.
  - In cycle N+1, operand = `fwd` ? forwarded value : `mem_rdata`.
  - In cycle N+1, `mem_wdata` = sat(operand + OCC_INC) or sat(operand − FREE_DEC); `mem_waddr` = S1 address; `mem_we` = 1.
- Saturation: compute in CELL_BITS+1 bits, then clamp to [−2^(CELL_BITS−1), 2^(CELL_BITS−1)−1].
- `busy` = (state==CLEAR) | S1.valid.
- CLEAR: each cycle `mem_we`=1, `mem_waddr`=counter, `mem_wdata`=0, and the counter increments. The counter wraps to 0 on exit.
- Dropped updates set `update_dropped` (cleared only by reset). An update is dropped when:
  - `write_enable`=1 in any CLEAR cycle, or
  - `write_enable`=1 in the same cycle that `clear` is honoured (clear wins).
- A `clear` with `busy`=1 is ignored. There is no flag for this and no queuing.

## Timing
- Update latency: sampled at edge N, RAM write commits at edge N+1. `busy` is high in cycle N+1.
- Sustained throughput: 1 update per cycle, with no bubbles for any address pattern.
- Back-to-back updates to the same address use the forwarded value. Non-adjacent repeats, two or more cycles apart, read from RAM normally.
- Clear: honoured at edge N, so `busy` and `mem_we` are high for cycles N+1 … N+2^ADDR_BITS. `busy` falls in cycle N+2^ADDR_BITS+1.
- Reset asserted mid-clear or mid-update: outputs drop to their reset values asynchronously. A partially cleared map is left as is.
- The ray tracer only starts a ray when `busy`=0, so a clear cannot interleave with a ray. `update_dropped` flags violations of this rule.

## Structure
- Shared package `occupancy_pkg`:
  - `cell_t` (signed [CELL_BITS−1:0])
  - the `OCC_INC`/`FREE_DEC` defaults
  - the `updater_state_t` enum {IDLE, CLEAR}
- One sub-module, `occupancy_saturate`: combinational operand ± delta with clamp, parameterised on CELL_BITS.
- The top level holds the FSM, S1 registers, forwarding mux and clear counter.

## Test plan
- Map cleared; single occupied update at x=3, y=5 → one-cycle `mem_we` at N+1, `mem_waddr`=163, `mem_wdata`=4; `busy` high exactly one cycle.
- Three consecutive free updates to (7,2) from 0 → writes −1, −2, −3 on consecutive cycles (forwarding exercised).
- Saturation → cell at 125 with an occupied update writes 127; cell at −128 with a free update writes −128; cell at −127 with a free update writes −128.
- `clear` with `busy`=0 → 1024 writes, addresses 0…1023, data 0, `busy` high for exactly 1024 cycles; `clear` pulsed again mid-run has no effect.
- `write_enable` during CLEAR, or coincident with an honoured `clear` → no write to that cell other than the clear's write of 0, and `update_dropped`=1 and stays 1.
- `reset`=0 at clear counter 300 → `mem_we`, `busy`=0 immediately; after release, a clear restarts from address 0.

Source files
------------

// File: rtl/occupancy_updater_pkg.sv
// occupancy_pkg: shared types and default increments for the occupancy-map updater
//   cell_t          signed log-odds cell value
//   updater_state_t IDLE accepts updates, CLEAR zeroes the map
package occupancy_pkg;
  localparam int CELL_BITS_DEFAULT = 8;
  localparam int OCC_INC_DEFAULT = 4;
  localparam int FREE_DEC_DEFAULT = 1;
  typedef logic signed [CELL_BITS_DEFAULT-1:0] cell_t;
  typedef enum logic {IDLE, CLEAR} updater_state_t;
endpackage

// File: rtl/occupancy_updater_if.sv
// occupancy_updater_if: update stream from the ray tracer plus the map RAM ports
//   write_enable/cell_is_free/cell_x/cell_y  per-cell update stream
//   clear/busy/update_dropped                map clear request and status
//   mem_*                                    simple dual-port RAM, 1-cycle read
interface occupancy_updater_if import occupancy_pkg::*; #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5,
  parameter int CELL_BITS = CELL_BITS_DEFAULT
);
  logic write_enable, cell_is_free, clear, busy, update_dropped, mem_we;
  logic [X_BITS-1:0] cell_x;
  logic [Y_BITS-1:0] cell_y;
  logic [X_BITS+Y_BITS-1:0] mem_raddr, mem_waddr;
  logic signed [CELL_BITS-1:0] mem_rdata, mem_wdata;
  modport master(
    output write_enable, cell_is_free, cell_x, cell_y, clear, mem_rdata,
    input busy, update_dropped, mem_raddr, mem_waddr, mem_wdata, mem_we
  );
  modport slave(
    input write_enable, cell_is_free, cell_x, cell_y, clear, mem_rdata,
    output busy, update_dropped, mem_raddr, mem_waddr, mem_wdata, mem_we
  );
endinterface

// File: rtl/occupancy_updater_saturate.sv
// occupancy_saturate: operand plus OCC_INC or minus FREE_DEC, clamped to the signed cell range
//   operand  current cell value
//   is_free  1 subtracts FREE_DEC, 0 adds OCC_INC
//   result   clamped updated value
module occupancy_saturate #(
  parameter int CELL_BITS = 8,
  parameter int OCC_INC = 4,
  parameter int FREE_DEC = 1
)(
  input  logic signed [CELL_BITS-1:0] operand,
  input  logic                        is_free,
  output logic signed [CELL_BITS-1:0] result
);
  localparam logic signed [CELL_BITS:0] MAX = {2'b00, {(CELL_BITS-1){1'b1}}};
  localparam logic signed [CELL_BITS:0] MIN = {2'b11, {(CELL_BITS-1){1'b0}}};
  localparam logic signed [CELL_BITS:0] INC = OCC_INC[CELL_BITS:0];
  localparam logic signed [CELL_BITS:0] DEC = FREE_DEC[CELL_BITS:0];
  logic signed [CELL_BITS:0] ext, sum;
  assign ext = {operand[CELL_BITS-1], operand};
  assign sum = is_free ? ext - DEC : ext + INC;
  assign result = sum > MAX ? MAX[CELL_BITS-1:0] : sum < MIN ? MIN[CELL_BITS-1:0] : sum[CELL_BITS-1:0];
endmodule

// File: rtl/occupancy_updater.sv
// occupancy_updater: read-modify-write of occupancy log-odds cells, with map clear
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    update stream, status and map RAM ports (slave side)
module occupancy_updater import occupancy_pkg::*; #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5,
  parameter int CELL_BITS = CELL_BITS_DEFAULT,
  parameter int OCC_INC = OCC_INC_DEFAULT,
  parameter int FREE_DEC = FREE_DEC_DEFAULT
)(
  input logic clock,
  input logic reset,
  occupancy_updater_if.slave bus
);
  localparam int ADDR_BITS = X_BITS + Y_BITS;
  updater_state_t state, state_next;
  logic s1_valid, s1_free, s1_fwd, clear_go, accept, dropped;
  logic [ADDR_BITS-1:0] s1_addr, count, addr;
  logic signed [CELL_BITS-1:0] s1_fwd_data, operand, result;
  assign addr = {bus.cell_y, bus.cell_x};
  assign bus.mem_raddr = addr;
  assign bus.busy = state == CLEAR || s1_valid;
  assign clear_go = state == IDLE && bus.clear && !bus.busy;
  assign accept = state == IDLE && bus.write_enable && !clear_go;
  // RAM returns old data on read-during-write, so a back-to-back hit uses the value being written
  assign operand = s1_fwd ? s1_fwd_data : bus.mem_rdata;
  assign bus.mem_we = bus.busy;
  assign bus.mem_waddr = state == CLEAR ? count : s1_addr;
  assign bus.mem_wdata = s1_valid ? result : '0;
  assign bus.update_dropped = dropped;
  occupancy_saturate #(.CELL_BITS(CELL_BITS), .OCC_INC(OCC_INC), .FREE_DEC(FREE_DEC)) u_sat (
    .operand(operand),
    .is_free(s1_free),
    .result(result)
  );
  always_comb begin
    state_next = state;
    state_next = clear_go ? CLEAR : (state == CLEAR && count == '1) ? IDLE : state;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      s1_valid <= 1'b0;
      s1_free <= 1'b0;
      s1_fwd <= 1'b0;
      s1_addr <= '0;
      s1_fwd_data <= '0;
      dropped <= 1'b0;
    end else begin
      state <= state_next;
      count <= state == CLEAR ? count + 1'b1 : '0;
      s1_valid <= accept;
      s1_fwd <= accept && s1_valid && s1_addr == addr;
      if (accept) begin
        s1_addr <= addr;
        s1_free <= bus.cell_is_free;
        s1_fwd_data <= result;
      end
      dropped <= dropped | (bus.write_enable && (state == CLEAR || clear_go));
    end
  end
endmodule

// File: tb/tb_occupancy_updater.sv
// tb_occupancy_updater: directed checks of updates, forwarding, saturation, clear, drops and reset
module tb_occupancy_updater;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic signed [7:0] mem [1024];
  logic pre_we = 1'b0;
  logic [9:0] pre_addr = '0;
  logic signed [7:0] pre_data = '0;
  occupancy_updater_if #(.X_BITS(5), .Y_BITS(5), .CELL_BITS(8)) bus ();
  occupancy_updater #(.X_BITS(5), .Y_BITS(5), .CELL_BITS(8), .OCC_INC(4), .FREE_DEC(1)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    bus.mem_rdata <= mem[bus.mem_raddr];
    if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic poke(input int a, input int d);
    pre_we = 1'b1;
    pre_addr = 10'(a);
    pre_data = 8'(d);
    @(negedge clock);
    pre_we = 1'b0;
  endtask
  // Caller raises clear (and possibly write_enable) at the current negedge
  task automatic run_clear(input int we_at, input int clr_at, input int stop_at);
    @(negedge clock);
    bus.clear = 1'b0;
    bus.write_enable = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (i == stop_at) return;
      chk("clr_we", bus.mem_we, 1);
      chk("clr_busy", bus.busy, 1);
      chk("clr_addr", bus.mem_waddr, i);
      chk("clr_data", bus.mem_wdata, 0);
      bus.write_enable = i == we_at;
      bus.cell_x = 5'd3;
      bus.cell_y = 5'd5;
      bus.clear = i == clr_at;
      @(negedge clock);
    end
    bus.write_enable = 1'b0;
    bus.clear = 1'b0;
    chk("clr_done_busy", bus.busy, 0);
    chk("clr_done_we", bus.mem_we, 0);
  endtask
  task automatic burst(input int xs[3], input int ys[3], input int fr[3], input int ex[3]);
    for (int k = 0; k < 3; k++) begin
      bus.write_enable = 1'b1;
      bus.cell_x = 5'(xs[k]);
      bus.cell_y = 5'(ys[k]);
      bus.cell_is_free = fr[k] != 0;
      @(negedge clock);
      chk("burst_we", bus.mem_we, 1);
      chk("burst_addr", bus.mem_waddr, ys[k] * 32 + xs[k]);
      chk("burst_data", bus.mem_wdata, ex[k]);
    end
    bus.write_enable = 1'b0;
    @(negedge clock);
    chk("burst_idle", bus.busy, 0);
  endtask
  initial begin
    bus.write_enable = 1'b0;
    bus.cell_is_free = 1'b0;
    bus.cell_x = '0;
    bus.cell_y = '0;
    bus.clear = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_waddr", bus.mem_waddr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_dropped", bus.update_dropped, 0);
    reset = 1'b1;
    @(negedge clock);
    bus.clear = 1'b1;
    run_clear(-1, 500, 2000);
    chk("map_zero", mem[500], 0);
    chk("drop_clean", bus.update_dropped, 0);
    bus.write_enable = 1'b1;
    bus.cell_is_free = 1'b0;
    bus.cell_x = 5'd3;
    bus.cell_y = 5'd5;
    chk("pre_busy", bus.busy, 0);
    @(negedge clock);
    bus.write_enable = 1'b0;
    chk("one_we", bus.mem_we, 1);
    chk("one_busy", bus.busy, 1);
    chk("one_addr", bus.mem_waddr, 163);
    chk("one_data", bus.mem_wdata, 4);
    @(negedge clock);
    chk("one_busy_end", bus.busy, 0);
    chk("one_we_end", bus.mem_we, 0);
    chk("one_mem", mem[163], 4);
    burst('{7, 7, 7}, '{2, 2, 2}, '{1, 1, 1}, '{-1, -2, -3});
    chk("fwd_mem", mem[71], -3);
    burst('{7, 3, 7}, '{2, 5, 2}, '{0, 1, 0}, '{1, 3, 5});
    poke(10, 125);
    poke(11, -128);
    poke(12, -127);
    burst('{10, 11, 12}, '{0, 0, 0}, '{0, 1, 1}, '{127, -128, -128});
    bus.clear = 1'b1;
    run_clear(100, -1, 2000);
    chk("drop_in_clear", bus.update_dropped, 1);
    chk("clr_163", mem[163], 0);
    bus.clear = 1'b1;
    run_clear(-1, -1, 300);
    reset = 1'b0;
    #1;
    chk("arst_we", bus.mem_we, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_waddr", bus.mem_waddr, 0);
    chk("arst_dropped", bus.update_dropped, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("arst_idle", bus.busy, 0);
    bus.clear = 1'b1;
    run_clear(-1, -1, 2000);
    chk("restart_dropped", bus.update_dropped, 0);
    bus.clear = 1'b1;
    bus.write_enable = 1'b1;
    bus.cell_is_free = 1'b0;
    bus.cell_x = 5'd3;
    bus.cell_y = 5'd5;
    run_clear(-1, -1, 2000);
    chk("drop_coincident", bus.update_dropped, 1);
    @(negedge clock);
    @(negedge clock);
    chk("drop_sticky", bus.update_dropped, 1);
    chk("drop_no_write", bus.mem_we, 0);
    chk("drop_cell", mem[163], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
